// File: rtl/cpu_pkg.sv
// Shared definitions for the Mini SRC control unit: opcode encodings,
// FSM state enumeration and the instruction classes used by the sequencer.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    IDLE,
    FETCH0,
    FETCH1,
    FETCH2,
    T3,
    T4,
    T5,
    T6,
    T7,
    HALT
  } state_t;

  typedef enum logic [3:0] {
    IC_ALU,
    IC_IMM,
    IC_LD,
    IC_LDI,
    IC_ST,
    IC_BR,
    IC_MULDIV,
    IC_MFHI,
    IC_MFLO,
    IC_NOP,
    IC_HALT
  } iclass_t;

endpackage

// File: rtl/cu_decode.sv
// Opcode classifier: maps a 5-bit opcode to its instruction class and the
// number of the final execute step (3..7) of that class.
module cu_decode
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  output iclass_t    iclass,
  output logic [2:0] last_step
);

  // Group opcodes by their micro-step sequence; unknown opcodes act as nop.
  always_comb begin
    iclass = IC_NOP;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA,
      OP_SHL, OP_ROR, OP_ROL, OP_NEG, OP_NOT: iclass = IC_ALU;
      OP_ADDI, OP_ANDI, OP_ORI:               iclass = IC_IMM;
      OP_LD:                                  iclass = IC_LD;
      OP_LDI:                                 iclass = IC_LDI;
      OP_ST:                                  iclass = IC_ST;
      OP_BR:                                  iclass = IC_BR;
      OP_MUL, OP_DIV:                         iclass = IC_MULDIV;
      OP_MFHI:                                iclass = IC_MFHI;
      OP_MFLO:                                iclass = IC_MFLO;
      OP_HALT:                                iclass = IC_HALT;
      default:                                iclass = IC_NOP;
    endcase
  end

  // Final execute step per class; after it the sequencer refetches.
  always_comb begin
    last_step = 3'd3;
    case (iclass)
      IC_ALU, IC_IMM, IC_LDI: last_step = 3'd5;
      IC_LD, IC_ST:           last_step = 3'd7;
      IC_BR, IC_MULDIV:       last_step = 3'd6;
      default:                last_step = 3'd3;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Mini SRC control sequencer: fetch/execute FSM whose strobes and bus
// selects are decoded combinationally from the current state, the opcode
// in IR_Data[31:27] and the branch condition.
module control_unit
  import cpu_pkg::*;
#(
  parameter logic [4:0] ADDR_OP = 5'b00011
)
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR_Data,
  input  logic        con_output,
  output logic        PC_enable,
  output logic        PC_increment_enable,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        Z_enable,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        HI_enable,
  output logic        LO_enable,
  output logic        con_enable,
  output logic        read,
  output logic        write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        r_enable,
  output logic        r_select,
  output logic        BAout,
  output logic        PC_select,
  output logic        HI_select,
  output logic        LO_select,
  output logic        Z_HI_select,
  output logic        Z_LO_select,
  output logic        MDR_select,
  output logic        InPort_select,
  output logic        c_select,
  output logic [4:0]  alu_instruction,
  output logic        run
);

  state_t     state;
  logic       armed;
  logic [4:0] opcode;
  iclass_t    iclass;
  logic [2:0] last_step;
  logic       unused_ir;

  assign opcode    = IR_Data[31:27];
  assign unused_ir = ^IR_Data[26:0];

  cu_decode u_decode (
    .opcode    (opcode),
    .iclass    (iclass),
    .last_step (last_step)
  );

  function automatic logic [2:0] step_of(input state_t s);
    case (s)
      T3:      return 3'd3;
      T4:      return 3'd4;
      T5:      return 3'd5;
      T6:      return 3'd6;
      T7:      return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  function automatic state_t next_exec(input state_t s);
    case (s)
      T3:      return T4;
      T4:      return T5;
      T5:      return T6;
      T6:      return T7;
      default: return FETCH0;
    endcase
  endfunction

  // Sequencer. 'armed' spends the first edge after reset release in IDLE so
  // that FETCH0 starts on the second edge, giving downstream logic a full
  // cycle out of reset before the first PC/MAR load.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE:   if (armed) state <= FETCH0;
        FETCH0: state <= FETCH1;
        FETCH1: state <= FETCH2;
        FETCH2: state <= T3;
        T3, T4, T5, T6, T7: begin
          if (step_of(state) >= last_step)
            state <= (iclass == IC_HALT) ? HALT : FETCH0;
          else
            state <= next_exec(state);
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  // Micro-operation decode: each state/class pair raises its strobes and
  // exactly one bus source; everything else stays low.
  always_comb begin
    PC_enable           = 1'b0;
    PC_increment_enable = 1'b0;
    IR_enable           = 1'b0;
    Y_enable            = 1'b0;
    Z_enable            = 1'b0;
    MAR_enable          = 1'b0;
    MDR_enable          = 1'b0;
    HI_enable           = 1'b0;
    LO_enable           = 1'b0;
    con_enable          = 1'b0;
    read                = 1'b0;
    write               = 1'b0;
    Gra                 = 1'b0;
    Grb                 = 1'b0;
    Grc                 = 1'b0;
    r_enable            = 1'b0;
    r_select            = 1'b0;
    BAout               = 1'b0;
    PC_select           = 1'b0;
    HI_select           = 1'b0;
    LO_select           = 1'b0;
    Z_HI_select         = 1'b0;
    Z_LO_select         = 1'b0;
    MDR_select          = 1'b0;
    InPort_select       = 1'b0;
    c_select            = 1'b0;
    alu_instruction     = 5'b00000;
    case (state)
      FETCH0: begin
        PC_select           = 1'b1;
        MAR_enable          = 1'b1;
        PC_increment_enable = 1'b1;
      end
      FETCH1: begin
        read       = 1'b1;
        MDR_enable = 1'b1;
      end
      FETCH2: begin
        MDR_select = 1'b1;
        IR_enable  = 1'b1;
      end
      T3: begin
        case (iclass)
          IC_ALU, IC_IMM: begin
            Grb = 1'b1; r_select = 1'b1; Y_enable = 1'b1;
          end
          IC_LD, IC_LDI, IC_ST: begin
            Grb = 1'b1; r_select = 1'b1; BAout = 1'b1; Y_enable = 1'b1;
          end
          IC_BR: begin
            Gra = 1'b1; r_select = 1'b1; con_enable = 1'b1;
          end
          IC_MULDIV: begin
            Gra = 1'b1; r_select = 1'b1; Y_enable = 1'b1;
          end
          IC_MFHI: begin
            HI_select = 1'b1; Gra = 1'b1; r_enable = 1'b1;
          end
          IC_MFLO: begin
            LO_select = 1'b1; Gra = 1'b1; r_enable = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        case (iclass)
          IC_ALU: begin
            Grc = 1'b1; r_select = 1'b1; Z_enable = 1'b1;
            alu_instruction = opcode;
          end
          IC_IMM: begin
            c_select = 1'b1; Z_enable = 1'b1;
            alu_instruction = opcode;
          end
          IC_LD, IC_LDI, IC_ST: begin
            c_select = 1'b1; Z_enable = 1'b1;
            alu_instruction = ADDR_OP;
          end
          IC_BR: begin
            PC_select = 1'b1; Y_enable = 1'b1;
          end
          IC_MULDIV: begin
            Grb = 1'b1; r_select = 1'b1; Z_enable = 1'b1;
            alu_instruction = opcode;
          end
          default: ;
        endcase
      end
      T5: begin
        case (iclass)
          IC_ALU, IC_IMM, IC_LDI: begin
            Z_LO_select = 1'b1; Gra = 1'b1; r_enable = 1'b1;
          end
          IC_LD, IC_ST: begin
            Z_LO_select = 1'b1; MAR_enable = 1'b1;
          end
          IC_BR: begin
            c_select = 1'b1; Z_enable = 1'b1;
            alu_instruction = ADDR_OP;
          end
          IC_MULDIV: begin
            Z_LO_select = 1'b1; LO_enable = 1'b1;
          end
          default: ;
        endcase
      end
      T6: begin
        case (iclass)
          IC_LD: begin
            read = 1'b1; MDR_enable = 1'b1;
          end
          IC_ST: begin
            Gra = 1'b1; r_select = 1'b1; MDR_enable = 1'b1;
          end
          IC_BR: begin
            Z_LO_select = 1'b1; PC_enable = con_output;
          end
          IC_MULDIV: begin
            Z_HI_select = 1'b1; HI_enable = 1'b1;
          end
          default: ;
        endcase
      end
      T7: begin
        case (iclass)
          IC_LD: begin
            MDR_select = 1'b1; Gra = 1'b1; r_enable = 1'b1;
          end
          IC_ST: write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // run drops only while held in reset or once halted.
  always_comb begin
    run = (state != HALT) && !((state == IDLE) && clr);
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed and random instruction streams compared
// cycle by cycle against a step-table model of the Mini SRC micro-sequence.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] IR_Data = '0;
  logic        con_output = 1'b0;
  logic PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable;
  logic MAR_enable, MDR_enable, HI_enable, LO_enable, con_enable;
  logic read, write, Gra, Grb, Grc, r_enable, r_select, BAout;
  logic PC_select, HI_select, LO_select, Z_HI_select, Z_LO_select;
  logic MDR_select, InPort_select, c_select, run;
  logic [4:0] alu_instruction;

  control_unit #(.ADDR_OP(5'b00011)) dut (
    .clk(clk), .clr(clr), .IR_Data(IR_Data), .con_output(con_output),
    .PC_enable(PC_enable), .PC_increment_enable(PC_increment_enable),
    .IR_enable(IR_enable), .Y_enable(Y_enable), .Z_enable(Z_enable),
    .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .HI_enable(HI_enable),
    .LO_enable(LO_enable), .con_enable(con_enable), .read(read), .write(write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .r_enable(r_enable), .r_select(r_select),
    .BAout(BAout), .PC_select(PC_select), .HI_select(HI_select),
    .LO_select(LO_select), .Z_HI_select(Z_HI_select), .Z_LO_select(Z_LO_select),
    .MDR_select(MDR_select), .InPort_select(InPort_select), .c_select(c_select),
    .alu_instruction(alu_instruction), .run(run)
  );

  always #5 clk = ~clk;

  // Packed view of every output: [31] run, [30:26] alu, [25:18] bus selects.
  logic [31:0] obs;
  assign obs = {run, alu_instruction, c_select, InPort_select, MDR_select,
                Z_LO_select, Z_HI_select, LO_select, HI_select, PC_select,
                BAout, r_select, r_enable, Grc, Grb, Gra, write, read,
                con_enable, LO_enable, HI_enable, MDR_enable, MAR_enable,
                Z_enable, Y_enable, IR_enable, PC_increment_enable, PC_enable};

  localparam logic [31:0] M_PCEN   = 32'd1 << 0;
  localparam logic [31:0] M_PCINC  = 32'd1 << 1;
  localparam logic [31:0] M_IR     = 32'd1 << 2;
  localparam logic [31:0] M_Y      = 32'd1 << 3;
  localparam logic [31:0] M_Z      = 32'd1 << 4;
  localparam logic [31:0] M_MAR    = 32'd1 << 5;
  localparam logic [31:0] M_MDR    = 32'd1 << 6;
  localparam logic [31:0] M_HI     = 32'd1 << 7;
  localparam logic [31:0] M_LO     = 32'd1 << 8;
  localparam logic [31:0] M_CON    = 32'd1 << 9;
  localparam logic [31:0] M_RD     = 32'd1 << 10;
  localparam logic [31:0] M_WR     = 32'd1 << 11;
  localparam logic [31:0] M_GRA    = 32'd1 << 12;
  localparam logic [31:0] M_GRB    = 32'd1 << 13;
  localparam logic [31:0] M_GRC    = 32'd1 << 14;
  localparam logic [31:0] M_REN    = 32'd1 << 15;
  localparam logic [31:0] M_RSEL   = 32'd1 << 16;
  localparam logic [31:0] M_BA     = 32'd1 << 17;
  localparam logic [31:0] M_PCSEL  = 32'd1 << 18;
  localparam logic [31:0] M_HISEL  = 32'd1 << 19;
  localparam logic [31:0] M_LOSEL  = 32'd1 << 20;
  localparam logic [31:0] M_ZHI    = 32'd1 << 21;
  localparam logic [31:0] M_ZLO    = 32'd1 << 22;
  localparam logic [31:0] M_MDRSEL = 32'd1 << 23;
  localparam logic [31:0] M_CSEL   = 32'd1 << 25;
  localparam logic [31:0] M_RUN    = 32'd1 << 31;
  localparam logic [4:0]  ADDR_OP  = 5'b00011;

  localparam int K_ALU = 0, K_IMM = 1, K_LD = 2, K_LDI = 3, K_ST = 4, K_BR = 5;
  localparam int K_MD = 6, K_MFHI = 7, K_MFLO = 8, K_NOP = 9, K_HALT = 10;

  int   n_checks = 0;
  int   n_err = 0;
  logic write_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int kind(input logic [4:0] op);
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd17, 5'd18: return K_ALU;
      5'd12, 5'd13, 5'd14: return K_IMM;
      5'd0:  return K_LD;
      5'd1:  return K_LDI;
      5'd2:  return K_ST;
      5'd19: return K_BR;
      5'd15, 5'd16: return K_MD;
      5'd24: return K_MFHI;
      5'd25: return K_MFLO;
      5'd27: return K_HALT;
      default: return K_NOP;
    endcase
  endfunction

  // Number of execute cycles following the three fetch cycles.
  function automatic int exec_len(input logic [4:0] op);
    case (kind(op))
      K_ALU, K_IMM, K_LDI: return 3;
      K_LD, K_ST:          return 5;
      K_BR, K_MD:          return 4;
      default:             return 1;
    endcase
  endfunction

  function automatic logic [31:0] alu_f(input logic [4:0] v);
    return {1'b0, v, 26'd0};
  endfunction

  // Expected output word k cycles after FETCH0 of instruction op.
  function automatic logic [31:0] exp_word(input logic [4:0] op, input int k, input logic con);
    logic [31:0] e;
    int s;
    int c;
    e = M_RUN;
    s = k - 3;
    c = kind(op);
    if (k == 0)      e |= M_PCSEL | M_MAR | M_PCINC;
    else if (k == 1) e |= M_RD | M_MDR;
    else if (k == 2) e |= M_MDRSEL | M_IR;
    else if (c == K_ALU || c == K_IMM) begin
      if (s == 0) e |= M_GRB | M_RSEL | M_Y;
      if (s == 1) e |= M_Z | alu_f(op) | ((c == K_ALU) ? (M_GRC | M_RSEL) : M_CSEL);
      if (s == 2) e |= M_ZLO | M_GRA | M_REN;
    end else if (c == K_LD || c == K_LDI || c == K_ST) begin
      if (s == 0) e |= M_GRB | M_RSEL | M_BA | M_Y;
      if (s == 1) e |= M_CSEL | M_Z | alu_f(ADDR_OP);
      if (s == 2) e |= (c == K_LDI) ? (M_ZLO | M_GRA | M_REN) : (M_ZLO | M_MAR);
      if (s == 3) e |= (c == K_LD) ? (M_RD | M_MDR) : (M_GRA | M_RSEL | M_MDR);
      if (s == 4) e |= (c == K_LD) ? (M_MDRSEL | M_GRA | M_REN) : M_WR;
    end else if (c == K_BR) begin
      if (s == 0) e |= M_GRA | M_RSEL | M_CON;
      if (s == 1) e |= M_PCSEL | M_Y;
      if (s == 2) e |= M_CSEL | M_Z | alu_f(ADDR_OP);
      if (s == 3) e |= M_ZLO | (con ? M_PCEN : 32'd0);
    end else if (c == K_MD) begin
      if (s == 0) e |= M_GRA | M_RSEL | M_Y;
      if (s == 1) e |= M_GRB | M_RSEL | M_Z | alu_f(op);
      if (s == 2) e |= M_ZLO | M_LO;
      if (s == 3) e |= M_ZHI | M_HI;
    end else if (c == K_MFHI) e |= M_HISEL | M_GRA | M_REN;
    else if (c == K_MFLO)     e |= M_LOSEL | M_GRA | M_REN;
    return e;
  endfunction

  // Entry: 1 time unit after the edge that entered FETCH0. Exit: same point
  // of the following FETCH0 (or HALT).
  task automatic run_instr(input string name, input logic [31:0] ir, input logic con);
    logic [4:0] op;
    int n;
    op = ir[31:27];
    n  = 3 + exec_len(op);
    IR_Data    = ir;
    con_output = con;
    #1;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin @(posedge clk); #2; end
      chk($sformatf("%s op=%0d step=%0d", name, op, k), obs, exp_word(op, k, con));
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    #1;
    chk("reset_assert", obs, 32'd0);
    @(posedge clk); #1;
    chk("reset_hold", obs, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("idle_released", obs, M_RUN);
    @(posedge clk); #1;
    chk("idle_first_edge", obs, M_RUN);
    @(posedge clk); #1;
  endtask

  // Continuous invariants sampled mid-cycle.
  always @(negedge clk) begin
    chk("bus_select_onehot", {31'd0, ($countones(obs[25:18]) <= 1)}, 32'd1);
    chk("read_and_write", {31'd0, (read & write)}, 32'd0);
    chk("lo_and_hi", {31'd0, (LO_enable & HI_enable)}, 32'd0);
    if (write) write_seen = 1'b1;
  end

  initial begin
    logic [31:0] ir;
    logic [4:0]  op;
    #2;
    do_reset();

    run_instr("add",     {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0}, 1'b0);
    run_instr("ld",      {5'b00000, 4'd1, 4'd0, 19'h55}, 1'b0);
    run_instr("br_c0",   {5'b10011, 4'd2, 4'd0, 19'h10}, 1'b0);
    run_instr("br_c1",   {5'b10011, 4'd2, 4'd0, 19'h10}, 1'b1);
    run_instr("mul",     {5'b10000, 4'd3, 4'd4, 19'd0}, 1'b0);
    run_instr("div",     {5'b01111, 4'd5, 4'd6, 19'd0}, 1'b1);
    run_instr("mfhi",    {5'b11000, 4'd7, 23'd0}, 1'b0);
    run_instr("mflo",    {5'b11001, 4'd8, 23'd0}, 1'b0);
    run_instr("ldi",     {5'b00001, 4'd2, 4'd1, 19'h7}, 1'b0);
    run_instr("st",      {5'b00010, 4'd1, 4'd2, 19'h20}, 1'b1);
    run_instr("addi",    {5'b01100, 4'd3, 4'd3, 19'h1}, 1'b0);
    run_instr("not",     {5'b10010, 4'd4, 4'd5, 19'd0}, 1'b1);
    run_instr("nop",     {5'b11010, 27'd0}, 1'b0);
    run_instr("undef",   {5'b10100, 27'h123}, 1'b1);

    for (int i = 0; i < 60; i++) begin
      op = 5'($urandom_range(0, 30));
      if (op >= 5'd27) op = op + 5'd1;
      ir = {op, 27'($urandom)};
      run_instr("rand", ir, 1'($urandom_range(0, 1)));
    end

    // Abort a store in T4 with clr; nothing may remain asserted.
    write_seen = 1'b0;
    IR_Data    = {5'b00010, 4'd1, 4'd2, 19'h40};
    con_output = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(posedge clk); #2; end
      chk($sformatf("st_abort step=%0d", k), obs, exp_word(5'b00010, k, 1'b0));
    end
    #2;
    clr = 1'b1;
    #1;
    chk("clr_mid_t4", obs, 32'd0);
    chk("st_abort_no_write", {31'd0, write_seen}, 32'd0);
    do_reset();
    run_instr("add_after_abort", {5'b00100, 4'd1, 4'd2, 4'd3, 15'd0}, 1'b0);

    // Halt and stay halted regardless of inputs.
    run_instr("halt", {5'b11011, 27'd0}, 1'b1);
    for (int i = 0; i < 20; i++) begin
      IR_Data    = $urandom;
      con_output = 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("halt_hold %0d", i), obs, 32'd0);
      @(posedge clk); #1;
    end
    do_reset();
    run_instr("add_after_halt", {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0}, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
